// File: rtl/usr_shift_engine_pkg.sv
// Shared definitions for the universal shift engine: command modes, FSM states
// and the rule for which commands finish without stepping.
package usr_shift_engine_pkg;

   typedef enum logic [2:0] {
      MODE_HOLD  = 3'd0,
      MODE_LOAD  = 3'd1,
      MODE_SHL   = 3'd2,
      MODE_SHR   = 3'd3,
      MODE_ROL   = 3'd4,
      MODE_ROR   = 3'd5,
      MODE_ASR   = 3'd6,
      MODE_SIN_L = 3'd7
   } mode_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Commands that complete on the accept edge and go straight to DONE.
   function automatic logic finishes_at_accept(input logic [2:0] mode, input logic zero_count);
      return (mode == MODE_HOLD) || (mode == MODE_LOAD) || zero_count;
   endfunction

endpackage

// File: rtl/usr_shift_engine_step_unit.sv
// Combinational single-bit step: next register value and the bit shifted out.
module usr_step_unit
   import usr_shift_engine_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  mode_t             i_mode,
   input  logic [WIDTH-1:0]  i_reg,
   input  logic              i_ser_in,
   output logic [WIDTH-1:0]  o_next_reg,
   output logic              o_out_bit
);

   always_comb begin
      o_next_reg = i_reg;
      o_out_bit  = 1'b0;
      case (i_mode)
         MODE_SHL: begin
            o_next_reg = {i_reg[WIDTH-2:0], 1'b0};
            o_out_bit  = i_reg[WIDTH-1];
         end
         MODE_SHR: begin
            o_next_reg = {1'b0, i_reg[WIDTH-1:1]};
            o_out_bit  = i_reg[0];
         end
         MODE_ROL: begin
            o_next_reg = {i_reg[WIDTH-2:0], i_reg[WIDTH-1]};
            o_out_bit  = i_reg[WIDTH-1];
         end
         MODE_ROR: begin
            o_next_reg = {i_reg[0], i_reg[WIDTH-1:1]};
            o_out_bit  = i_reg[0];
         end
         MODE_ASR: begin
            o_next_reg = {i_reg[WIDTH-1], i_reg[WIDTH-1:1]};
            o_out_bit  = i_reg[0];
         end
         MODE_SIN_L: begin
            o_next_reg = {i_reg[WIDTH-2:0], i_ser_in};
            o_out_bit  = i_reg[WIDTH-1];
         end
         // HOLD and LOAD never reach the step path; they pass the register through.
         default: begin
            o_next_reg = i_reg;
            o_out_bit  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/usr_shift_engine.sv
// Multi-step universal shift register: accepts one command per handshake,
// runs up to MAX_STEPS single-bit steps, then pulses out_valid for one cycle.
module usr_shift_engine
   import usr_shift_engine_pkg::*;
#(
   parameter  int WIDTH     = 8,
   parameter  int MAX_STEPS = 15,
   localparam int CW        = $clog2(MAX_STEPS + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_mode,
   input  logic [CW-1:0]     cmd_count,
   input  logic [WIDTH-1:0]  cmd_data,
   input  logic              ser_in,
   output logic [WIDTH-1:0]  reg_out,
   output logic              ser_out,
   output logic              out_valid,
   output logic              busy
);

   state_t            r_state;
   mode_t             r_mode;
   logic [CW-1:0]     r_steps_left;
   logic [WIDTH-1:0]  r_reg;
   logic              r_ser;
   logic              r_out_valid;
   logic              r_busy;
   logic              r_ready;

   logic [WIDTH-1:0]  w_next_reg;
   logic              w_out_bit;

   usr_step_unit #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_mode     (r_mode),
      .i_reg      (r_reg),
      .i_ser_in   (ser_in),
      .o_next_reg (w_next_reg),
      .o_out_bit  (w_out_bit)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_mode       <= MODE_HOLD;
         r_steps_left <= '0;
         r_reg        <= '0;
         r_ser        <= 1'b0;
         r_out_valid  <= 1'b0;
         r_busy       <= 1'b0;
         r_ready      <= 1'b1;
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_busy  <= 1'b1;
                  r_ready <= 1'b0;
                  if (finishes_at_accept(cmd_mode, cmd_count == '0)) begin
                     if (cmd_mode == MODE_LOAD) begin
                        r_reg <= cmd_data;
                        r_ser <= 1'b0;
                     end
                     r_out_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_mode       <= mode_t'(cmd_mode);
                     r_steps_left <= cmd_count;
                     r_state      <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               r_reg        <= w_next_reg;
               r_ser        <= w_out_bit;
               r_steps_left <= r_steps_left - 1'b1;
               if (r_steps_left == CW'(1)) begin
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign reg_out   = r_reg;
   assign ser_out   = r_ser;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign cmd_ready = r_ready;

endmodule

// File: tb/tb_usr_shift_engine.sv
// Bench for usr_shift_engine: directed scenarios with literal expectations plus
// randomized commands, all checked every cycle against a queue-based model.
module tb_usr_shift_engine;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [2:0] cmd_mode = 3'd0;
   logic [3:0] cmd_count = 4'd0;
   logic [7:0] cmd_data = 8'd0;
   logic       ser_in;
   logic       cmd_ready, ser_out, out_valid, busy;
   logic [7:0] reg_out;

   int checks = 0;
   int errors = 0;
   int last_wait = 0;
   bit rand_ser = 1'b0;
   bit ser_fixed = 1'b0;

   always #5 clk = ~clk;

   usr_shift_engine #(.WIDTH(8), .MAX_STEPS(15)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_mode  (cmd_mode),
      .cmd_count (cmd_count),
      .cmd_data  (cmd_data),
      .ser_in    (ser_in),
      .reg_out   (reg_out),
      .ser_out   (ser_out),
      .out_valid (out_valid),
      .busy      (busy)
   );

   always @(negedge clk) begin
      logic [31:0] rnd;
      rnd = $urandom;
      ser_in = rand_ser ? rnd[0] : ser_fixed;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each accepted command becomes a list of pending per-edge operations:
   // N shift steps (last one flagged) followed by one return-to-idle.
   typedef struct {
      bit idle;
      int mode;
      bit last;
   } op_t;

   op_t q[$];
   int  m_reg = 0;
   int  m_ser = 0;
   bit  e_valid = 0, e_busy = 0, e_ready = 1;
   bit  model_on = 0;

   function automatic void apply_step(int mode, int sin);
      int r;
      r = m_reg;
      case (mode)
         2: begin m_reg = (r << 1) & 255;              m_ser = (r >> 7) & 1; end
         3: begin m_reg = r >> 1;                      m_ser = r & 1;        end
         4: begin m_reg = ((r << 1) | (r >> 7)) & 255; m_ser = (r >> 7) & 1; end
         5: begin m_reg = (r >> 1) | ((r & 1) << 7);   m_ser = r & 1;        end
         6: begin m_reg = (r >> 1) | (r & 128);        m_ser = r & 1;        end
         7: begin m_reg = ((r << 1) | sin) & 255;      m_ser = (r >> 7) & 1; end
         default: ;
      endcase
   endfunction

   always @(posedge clk) begin
      op_t op;
      int  m, n;
      if (reset) begin
         q.delete();
         m_reg = 0; m_ser = 0;
         e_valid = 0; e_busy = 0; e_ready = 1;
         model_on = 1;
      end else if (q.size() > 0) begin
         op = q.pop_front();
         if (op.idle) begin
            e_valid = 0; e_busy = 0; e_ready = 1;
         end else begin
            apply_step(op.mode, int'(ser_in));
            e_valid = op.last;
         end
      end else if (cmd_valid) begin
         m = int'(cmd_mode);
         n = int'(cmd_count);
         e_busy = 1; e_ready = 0;
         if (m == 0 || m == 1 || n == 0) begin
            if (m == 1) begin
               m_reg = int'(cmd_data);
               m_ser = 0;
            end
            e_valid = 1;
         end else begin
            e_valid = 0;
            for (int k = 1; k <= n; k++) q.push_back('{idle: 1'b0, mode: m, last: (k == n)});
         end
         q.push_back('{idle: 1'b1, mode: 0, last: 1'b0});
      end else begin
         e_valid = 0;
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         check("reg_out",   {24'd0, reg_out}, m_reg);
         check("ser_out",   {31'd0, ser_out}, m_ser);
         check("out_valid", {31'd0, out_valid}, {31'd0, e_valid});
         check("busy",      {31'd0, busy}, {31'd0, e_busy});
         check("cmd_ready", {31'd0, cmd_ready}, {31'd0, e_ready});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input int mode, input int cnt, input int data);
      int          waited;
      logic [31:0] rnd;
      logic [31:0] mv, cv, dv;
      waited = 0;
      mv = mode; cv = cnt; dv = data;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_mode  = mv[2:0];
      cmd_count = cv[3:0];
      cmd_data  = dv[7:0];
      while (!cmd_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      last_wait = waited;
      if (!cmd_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout: cmd_ready still 0 after %0d cycles, expected 1", waited);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      rnd = $urandom;
      cmd_mode  = rnd[2:0];
      cmd_count = rnd[6:3];
      cmd_data  = rnd[15:8];
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          pulses;
      logic [31:0] rnd;

      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_reg",   {24'd0, reg_out}, 32'h00);
      check("rst_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_busy",  {31'd0, busy}, 32'd0);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      reset = 1'b0;

      send(1, 0, 'hA5);
      @(negedge clk);
      check("load_reg",   {24'd0, reg_out}, 32'hA5);
      check("load_valid", {31'd0, out_valid}, 32'd1);
      check("load_ser",   {31'd0, ser_out}, 32'd0);
      @(negedge clk);
      check("load_valid_drop", {31'd0, out_valid}, 32'd0);

      send(4, 3, 0);
      @(negedge clk);
      check("rol_c1_reg",   {24'd0, reg_out}, 32'hA5);
      check("rol_c1_ready", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
      check("rol_c2_reg", {24'd0, reg_out}, 32'h4B);
      @(negedge clk);
      check("rol_c3_reg", {24'd0, reg_out}, 32'h96);
      @(negedge clk);
      check("rol_c4_reg",   {24'd0, reg_out}, 32'h2D);
      check("rol_c4_valid", {31'd0, out_valid}, 32'd1);
      check("rol_c4_ser",   {31'd0, ser_out}, 32'd1);
      check("rol_c4_ready", {31'd0, cmd_ready}, 32'd0);

      send(1, 0, 'h90);
      send(6, 2, 0);
      repeat (3) @(negedge clk);
      check("asr_reg",   {24'd0, reg_out}, 32'hE4);
      check("asr_valid", {31'd0, out_valid}, 32'd1);
      check("asr_ser",   {31'd0, ser_out}, 32'd0);

      send(3, 9, 0);
      pulses = 0;
      repeat (14) begin
         @(negedge clk);
         pulses += int'(out_valid);
      end
      check("shr9_pulses", pulses, 1);
      check("shr9_reg", {24'd0, reg_out}, 32'h00);

      ser_fixed = 1'b1;
      send(1, 0, 'h00);
      send(7, 4, 0);
      repeat (5) @(negedge clk);
      check("sinl_reg",   {24'd0, reg_out}, 32'h0F);
      check("sinl_valid", {31'd0, out_valid}, 32'd1);
      ser_fixed = 1'b0;

      send(5, 0, 'h33);
      @(negedge clk);
      check("cnt0_reg",   {24'd0, reg_out}, 32'h0F);
      check("cnt0_valid", {31'd0, out_valid}, 32'd1);

      send(1, 0, 'hFF);
      send(3, 7, 0);
      repeat (4) @(negedge clk);
      check("midrst_pre_reg", {24'd0, reg_out}, 32'h1F);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_reg",   {24'd0, reg_out}, 32'h00);
      check("midrst_ready", {31'd0, cmd_ready}, 32'd1);
      check("midrst_busy",  {31'd0, busy}, 32'd0);
      check("midrst_valid", {31'd0, out_valid}, 32'd0);
      pulses = 0;
      repeat (10) begin
         @(negedge clk);
         pulses += int'(out_valid);
      end
      check("midrst_no_pulse", pulses, 0);

      // A LOAD offered while a 5-step rotate runs waits for cmd_ready.
      send(4, 5, 'h11);
      send(1, 0, 'h3C);
      check("hold_wait", last_wait, 6);
      @(negedge clk);
      check("hold_reg", {24'd0, reg_out}, 32'h3C);

      rand_ser = 1'b1;
      for (int i = 0; i < 300; i++) begin
         rnd = $urandom;
         repeat (int'(rnd[1:0])) @(negedge clk);
         send(int'(rnd[4:2]), int'(rnd[8:5]), int'(rnd[16:9]));
         if (rnd[31:26] == 6'd0) begin
            repeat (int'(rnd[19:17])) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
         end
      end
      repeat (20) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
